// File: rtl/fpu_pkg.sv
// Shared FPU package: binary32 field widths, operand struct and classification helpers.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Any NaN, quiet or signalling: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(fp32_t v);
    return (v.exp == EXP_MAX) && (v.man != '0);
  endfunction

  // Signed zero: exponent and mantissa both clear.
  function automatic logic is_zero(fp32_t v);
    return (v.exp == '0) && (v.man == '0);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of one binary32 operand.
module fp_classify
  import fpu_pkg::*;
(
  input  fp32_t op,
  output logic  nan,
  output logic  zero,
  output logic  inf,
  output logic  sub
);

  // Exactly one of these, or none for a normal number, is set per operand.
  always_comb begin
    nan  = is_nan(op);
    zero = is_zero(op);
    inf  = (op.exp == EXP_MAX) && (op.man == '0);
    sub  = (op.exp == '0) && (op.man != '0);
  end

endmodule

// File: rtl/fp_feq.sv
// binary32 equality comparator (FEQ.S): registered equal and NaN flags, one-cycle latency.
module fp_feq
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [FP_W-1:0] x1,
  input  logic [FP_W-1:0] x2,
  output logic            y,
  output logic            valid
);

  fp32_t op1;
  fp32_t op2;
  logic  nan1, zero1, inf1, sub1;
  logic  nan2, zero2, inf2, sub2;
  logic  same_bits;
  logic  norm1, norm2;
  logic  y_d, valid_d;
  logic  y_q, valid_q;

  assign op1 = x1;
  assign op2 = x2;

  fp_classify u_cls1 (
    .op   (op1),
    .nan  (nan1),
    .zero (zero1),
    .inf  (inf1),
    .sub  (sub1)
  );

  fp_classify u_cls2 (
    .op   (op2),
    .nan  (nan2),
    .zero (zero2),
    .inf  (inf2),
    .sub  (sub2)
  );

  // Equality decided per class: zeros ignore sign, infinities need matching sign,
  // finite non-zero values need identical encodings; NaN matches no class.
  always_comb begin
    y_d       = 1'b0;
    valid_d   = 1'b0;
    same_bits = (x1 == x2);
    norm1     = !(nan1 || zero1 || inf1 || sub1);
    norm2     = !(nan2 || zero2 || inf2 || sub2);
    valid_d   = nan1 || nan2;
    y_d       = (zero1 && zero2)
             || (inf1 && inf2 && (op1.sign == op2.sign))
             || (sub1 && sub2 && same_bits)
             || (norm1 && norm2 && same_bits);
  end

  // Output registers; reset wins over the data update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_fp_feq.sv
// Self-checking bench for fp_feq: directed cases plus a randomized sweep against a real-valued model.
module tb_fp_feq;

  logic        clk;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        y;
  logic        valid;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Result expected for the pair currently held in the DUT registers.
  logic  pend;
  logic  pend_y;
  logic  pend_v;
  string pend_tag;

  logic [22:0] corners [8];

  fp_feq dut (
    .clk   (clk),
    .rstn  (rstn),
    .x1    (x1),
    .x2    (x2),
    .y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (x1=%h x2=%h)", tag, got, exp, x1, x2);
    end
  endtask

  // Numeric value of a finite binary32 encoding, built from its fields.
  function automatic real fval(logic [31:0] v);
    int  e;
    real m;
    real r;
    e = int'(v[30:23]);
    if (e == 0) begin
      m = real'(v[22:0]);
      r = m * (2.0 ** (-149));
    end else begin
      m = real'(v[22:0]) + 8388608.0;
      r = m * (2.0 ** (e - 150));
    end
    return v[31] ? -r : r;
  endfunction

  // Reference: NaN is unordered, infinities compare by sign, everything else by real value.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic ey, output logic ev);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    ev = a_nan || b_nan;
    if (ev)
      ey = 1'b0;
    else if (a_inf || b_inf)
      ey = a_inf && b_inf && (a[31] == b[31]);
    else
      ey = (fval(a) == fval(b));
  endtask

  // Drive one pair per cycle; the previous pair's result is checked on the same negedge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic ey, ev;
    @(negedge clk);
    if (pend) begin
      chk({pend_tag, "_y"}, y, pend_y);
      chk({pend_tag, "_v"}, valid, pend_v);
    end
    x1 = a;
    x2 = b;
    model(a, b, ey, ev);
    pend     = 1'b1;
    pend_y   = ey;
    pend_v   = ev;
    pend_tag = tag;
  endtask

  task automatic flush();
    @(negedge clk);
    if (pend) begin
      chk({pend_tag, "_y"}, y, pend_y);
      chk({pend_tag, "_v"}, valid, pend_v);
    end
    pend = 1'b0;
  endtask

  function automatic logic [22:0] pick_man(int idx);
    if (idx == 7) return 23'($urandom);
    return corners[idx];
  endfunction

  initial begin
    logic [22:0] m1, m2, mask;
    logic        s1, s2;
    logic [7:0]  e;

    n_cmp = 0;
    n_bad = 0;
    pend  = 1'b0;
    corners[0] = 23'h000000;
    corners[1] = 23'h000001;
    corners[2] = 23'h000002;
    corners[3] = 23'h380000;
    corners[4] = 23'h400000;
    corners[5] = 23'h5FFFFF;
    corners[6] = 23'h7FFFFF;
    corners[7] = 23'h000000;

    // Reset held two cycles with equal operands: outputs stay cleared.
    rstn = 1'b0;
    x1   = 32'h3F800000;
    x2   = 32'h3F800000;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_y", y, 1'b0);
      chk("rst_v", valid, 1'b0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_y", y, 1'b1);
    chk("rel_v", valid, 1'b0);

    // Directed cases, applied back to back.
    apply("pm_zero",  32'h00000000, 32'h80000000);
    apply("sub_zero", 32'h00000001, 32'h00000000);
    apply("qnan_eq",  32'h7FC00000, 32'h7FC00000);
    apply("snan",     32'h7F800001, 32'h3F800000);
    apply("inf_eq",   32'h7F800000, 32'h7F800000);
    apply("inf_pm",   32'h7F800000, 32'hFF800000);
    apply("sign",     32'h3F800000, 32'hBF800000);
    apply("lsb",      32'h3F800000, 32'h3F800001);
    apply("sub_eq",   32'h00400000, 32'h00400000);
    apply("sub_sign", 32'h00400000, 32'h80400000);
    apply("mm_zero",  32'h80000000, 32'h80000000);
    flush();

    // Explicit pipeline sequence: equal, NaN, unequal on consecutive cycles.
    apply("pipe_eq",  32'h40490FDB, 32'h40490FDB);
    apply("pipe_nan", 32'hFFC00001, 32'h40490FDB);
    apply("pipe_ne",  32'h40490FDB, 32'h40490FDA);
    flush();

    // Same exponent, every corner mantissa, random signs.
    for (int ei = 0; ei < 256; ei++) begin
      for (int c = 0; c < 8; c++) begin
        m1 = pick_man(c);
        s1 = 1'($urandom);
        s2 = 1'($urandom);
        apply("diag", {s1, 8'(ei), m1}, {s2, 8'(ei), m1});
      end
    end

    // All exponent pairs with random signs and corner mantissas.
    for (int e1 = 0; e1 < 256; e1++) begin
      for (int e2 = 0; e2 < 256; e2++) begin
        m1 = pick_man(int'($urandom_range(0, 7)));
        m2 = ($urandom_range(0, 3) == 0) ? m1 : pick_man(int'($urandom_range(0, 7)));
        s1 = 1'($urandom);
        s2 = 1'($urandom);
        apply("sweep", {s1, 8'(e1), m1}, {s2, 8'(e2), m2});
      end
    end

    // Same exponent and sign, mantissas differing only in the low k bits.
    for (int k = 0; k < 23; k++) begin
      mask = (k == 0) ? 23'd0 : 23'((32'd1 << k) - 32'd1);
      for (int t = 0; t < 64; t++) begin
        e  = 8'($urandom);
        m1 = 23'($urandom);
        m2 = m1 ^ (23'($urandom) & mask);
        s1 = 1'($urandom);
        apply("lowk", {s1, e, m1}, {s1, e, m2});
      end
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
